// File: rtl/regfile_onehot_wr.sv
// 32-entry register file that uses the write decoder's one-hot select directly.
// Define REGFILE_BYPASS_EN to forward same-cycle legal writes to the read ports.
module regfile_onehot_wr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic [31:0]      en,
    input  logic [WIDTH-1:0] WD,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             onehot_err
);

    logic [WIDTH-1:0] regs [32];
    logic             onehot;
    logic             legal;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign onehot = (en != 32'd0) && ((en & (en - 32'd1)) == 32'd0);
    assign legal  = WE && onehot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            onehot_err <= 1'b0;
        end else begin
            if (WE && !onehot) begin
                onehot_err <= 1'b1;
            end
            for (int i = 1; i < 32; i++) begin
                if (legal && en[i]) begin
                    regs[i] <= WD;
                end
            end
        end
    end

    always_comb begin
        RD1 = (A1 == 5'd0) ? '0 : regs[A1];
        RD2 = (A2 == 5'd0) ? '0 : regs[A2];
`ifdef REGFILE_BYPASS_EN
        if (legal && (A1 != 5'd0) && en[A1]) begin
            RD1 = WD;
        end
        if (legal && (A2 != 5'd0) && en[A2]) begin
            RD2 = WD;
        end
`else
`endif
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Randomized self-checking bench for regfile_onehot_wr against an array model.
// Honours REGFILE_BYPASS_EN when predicting same-cycle reads.
module tb_regfile_onehot_wr;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [31:0] en;
    logic [31:0] WD;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        onehot_err;

    int total = 0;
    int bad = 0;

    logic [31:0] model [32];
    logic        err_m;

    regfile_onehot_wr #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .WE(WE), .en(en), .WD(WD),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    // Expected read value given current model and current (pre-edge) inputs
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : model[a];
`ifdef REGFILE_BYPASS_EN
        if (WE && $countones(en) == 1 && a != 5'd0 && en[a]) v = WD;
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        err_m = 1'b0;
    endtask

    // One clock edge; inputs are driven and outputs sampled on negedges
    task automatic tick();
        @(posedge clk);
        if (WE) begin
            if ($countones(en) == 1) begin
                for (int i = 1; i < 32; i++)
                    if (en[i]) model[i] = WD;
            end else begin
                err_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        WE = 1'b1; en = 32'd1 << idx; WD = d;
        tick();
        WE = 1'b0; en = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 32; i++) wr(i, i * 32'h1111_1111);
        WE = 1'b1; en = 32'd1 << 4; WD = 32'hCAFE_0000;
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        for (int a = 0; a < 32; a++) begin
            A1 = a[4:0]; A2 = 5'(31 - a);
            #0.1;
            total++;
            if (RD1 !== 32'd0 || RD2 !== 32'd0) begin
                bad++;
                $display("FAIL reset_read a=%0d got %h/%h want 0", a, RD1, RD2);
            end
        end
        total++;
        if (onehot_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got %b want 0", onehot_err);
        end
        WE = 1'b0; en = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        A1 = 5'd4;
        #1;
        total++;
        if (RD1 !== 32'd0) begin
            bad++;
            $display("FAIL reset_midwrite got %h want 0", RD1);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) wr(i, 32'hA5A5_0000 | i);
        for (int a = 0; a < 32; a++) begin
            A1 = a[4:0]; A2 = a[4:0];
            #1;
            total++;
            if (RD1 !== ((a == 0) ? 32'd0 : (32'hA5A5_0000 | a)) || RD2 !== RD1) begin
                bad++;
                $display("FAIL sweep a=%0d got %h/%h want %h", a, RD1, RD2,
                         (a == 0) ? 32'd0 : (32'hA5A5_0000 | a));
            end
        end
        total++;
        if (onehot_err !== 1'b0) begin
            bad++;
            $display("FAIL sweep_err got %b want 0", onehot_err);
        end
    endtask

    task automatic test_illegal();
        WE = 1'b1; en = 32'h0000_0003; WD = 32'hDEAD_BEEF;
        tick();
        WE = 1'b0; en = 32'd0;
        A1 = 5'd1; A2 = 5'd0;
        #1;
        total++;
        if (RD1 !== 32'hA5A5_0001 || RD2 !== 32'd0 || onehot_err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_two got %h/%h err=%b want a5a50001/0 err=1",
                     RD1, RD2, onehot_err);
        end
        wr(5, 32'h55);
        A1 = 5'd5;
        #1;
        total++;
        if (RD1 !== 32'h55 || onehot_err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_follow got %h err=%b want 55 err=1", RD1, onehot_err);
        end
        do_reset();
        WE = 1'b1; en = 32'd0; WD = 32'h7777_7777;
        tick();
        WE = 1'b0;
        A1 = 5'd5; A2 = 5'd31;
        #1;
        total++;
        if (onehot_err !== 1'b1 || RD1 !== 32'd0 || RD2 !== 32'd0) begin
            bad++;
            $display("FAIL illegal_zero got err=%b rd=%h/%h want err=1 rd=0",
                     onehot_err, RD1, RD2);
        end
    endtask

    task automatic test_we_gating();
        do_reset();
        wr(7, 32'h0BAD_F00D);
        WE = 1'b0; WD = 32'h1234;
        en = 32'd1 << 7;
        repeat (3) tick();
        en = 32'hFFFF_FFFF;
        repeat (3) tick();
        A1 = 5'd7;
        #1;
        total++;
        if (RD1 !== 32'h0BAD_F00D || onehot_err !== 1'b0) begin
            bad++;
            $display("FAIL we_gating got %h err=%b want 0badf00d err=0", RD1, onehot_err);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pre;
        wr(9, 32'h11);
        A1 = 5'd9; A2 = 5'd9;
        WE = 1'b1; en = 32'd1 << 9; WD = 32'h22;
`ifdef REGFILE_BYPASS_EN
        pre = 32'h22;
`else
        pre = 32'h11;
`endif
        #1;
        total++;
        if (RD1 !== pre || RD2 !== pre) begin
            bad++;
            $display("FAIL same_cycle_pre got %h/%h want %h", RD1, RD2, pre);
        end
        tick();
        WE = 1'b0; en = 32'd0;
        #1;
        total++;
        if (RD1 !== 32'h22 || RD2 !== 32'h22) begin
            bad++;
            $display("FAIL same_cycle_post got %h/%h want 22", RD1, RD2);
        end
    endtask

    task automatic test_dual_port();
        wr(3, 32'h33);
        wr(30, 32'hF0);
        A1 = 5'd3; A2 = 5'd30;
        #1;
        total++;
        if (RD1 !== 32'h33 || RD2 !== 32'hF0) begin
            bad++;
            $display("FAIL dual_port got %h/%h want 33/f0", RD1, RD2);
        end
        A1 = 5'd30; A2 = 5'd3;
        #1;
        total++;
        if (RD1 !== 32'hF0 || RD2 !== 32'h33) begin
            bad++;
            $display("FAIL dual_swap got %h/%h want f0/33", RD1, RD2);
        end
        A1 = 5'd0;
        #1;
        total++;
        if (RD1 !== 32'd0) begin
            bad++;
            $display("FAIL dual_zero got %h want 0", RD1);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            WE = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) en = 32'd1 << $urandom_range(0, 31);
            else if ($urandom_range(0, 1) == 1) en = $urandom;
            else en = 32'd0;
            // keep the sticky flag mostly clear so legal traffic dominates
            if (n < 250 && $countones(en) != 1) WE = 1'b0;
            WD = $urandom;
            A1 = 5'($urandom_range(0, 31));
            A2 = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(A1);
            e2 = exp_rd(A2);
            total++;
            if (RD1 !== e1 || RD2 !== e2) begin
                bad++;
                $display("FAIL rand_read n=%0d a=%0d/%0d got %h/%h want %h/%h",
                         n, A1, A2, RD1, RD2, e1, e2);
            end
            tick();
            total++;
            if (onehot_err !== err_m) begin
                bad++;
                $display("FAIL rand_err n=%0d got %b want %b", n, onehot_err, err_m);
            end
        end
        WE = 1'b0; en = 32'd0;
        for (int a = 0; a < 32; a++) begin
            A1 = a[4:0];
            #1;
            total++;
            if (RD1 !== exp_rd(A1)) begin
                bad++;
                $display("FAIL rand_final a=%0d got %h want %h", a, RD1, exp_rd(A1));
            end
        end
    endtask

    initial begin
        reset = 1'b0; WE = 1'b0; en = 32'd0; WD = 32'd0; A1 = 5'd0; A2 = 5'd0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_sweep();
        test_illegal();
        test_we_gating();
        test_same_cycle();
        test_dual_port();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32-entry integer register file sitting directly downstream of the write decoder.
- Consumes the decoder's one-hot 32-bit enable vector as its write-select, instead of re-decoding the destination index.
- Provides two combinational read ports for the decode stage and one clocked write port for writeback.
- Guards the write path with a sticky one-hot integrity flag.

Parameters:
- WIDTH, 32, data width of each register and of the WD/RD1/RD2 buses.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion (0) clears state immediately; release is synchronous to the design's reset release.
- WE  input  1  global write enable from writeback stage.
- en  input  32  one-hot register select from write decoder; bit i selects register i.
- WD  input  WIDTH  write data.
- A1  input  5  read address, port 1.
- A2  input  5  read address, port 2.
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.
- onehot_err  output  1  sticky flag: a write was attempted with a non-one-hot en.

Behaviour:
- Storage: regs[31:0], each WIDTH bits. Register 0 is never written and always reads 0.
- Reset (reset==0, asynchronous):
  - regs[0..31] = 0; onehot_err = 0.
  - RD1/RD2 therefore read 0 for all addresses.
  - Reset asserted mid-write: the write is lost and state is cleared.
- Write legality: a write is legal when WE==1 and en has exactly one bit set (popcount==1).
- Legal write at rising clk with en[i]==1:
  - i in 1..31: regs[i] <= WD.
  - i==0: write discarded, no error.
- Illegal write (WE==1 and popcount(en)!=1, including en==0):
  - No register is modified.
  - onehot_err <= 1 on that edge and stays 1 until reset.
- WE==0: en and WD are ignored; no state change; onehot_err unaffected.
- Reads: combinational, zero latency.
  - RDn = (An==0) ? 0 : regs[An].
  - Without bypass, a same-cycle write becomes visible on the read ports only after the clock edge.
- A1==A2: both ports return identical data.
- Width rules: WD stored verbatim, no extension or truncation; the address is unsigned 5-bit.
- onehot_err has no clear input; only reset clears it.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When a legal write is pending this cycle (WE==1, en one-hot, en[An]==1, An!=0), RDn = WD combinationally, before the edge.
  - Illegal writes never forward.
  - Writes targeting x0 never forward.
- Not defined: no forwarding; reads always reflect stored state only.

Test Plan:
- Reset clears state: write regs[1..31] = i*0x1111_1111 via legal writes, then pull reset low mid-cycle (no clock edge) -> RD1/RD2 read 0 for every A1/A2 immediately; onehot_err = 0.
- Full sweep: for i=0..31 drive en = 1<<i, WD = 0xA5A5_0000|i, WE=1, one edge each; then read all 32 addresses -> RD = 0xA5A5_0000|i for i>=1, RD = 0 for address 0; onehot_err stays 0.
- Illegal enables:
  - en = 0x0000_0003, WE=1, WD = 0xDEAD_BEEF -> regs[0], regs[1] unchanged; onehot_err = 1 from that edge on.
  - A following legal write to regs[5] = 0x55 still succeeds; onehot_err remains 1 until reset.
  - en = 0, WE=1 -> onehot_err = 1, no register changes.
- WE gating: en = 1<<7, WD = 0x1234, WE=0, several edges -> regs[7] unchanged; onehot_err = 0, including with en = 0xFFFF_FFFF and WE=0.
- Same-cycle read/write: regs[9] = 0x11, then drive WE=1, en = 1<<9, WD = 0x22, A1 = A2 = 9, sample before the edge:
  - With REGFILE_BYPASS_EN: RD1 = RD2 = 0x22.
  - Without it: RD1 = RD2 = 0x11.
  - After the edge: 0x22 in both builds.
- Dual-port independence: regs[3] = 0x33, regs[30] = 0xF0 -> A1=3, A2=30 gives RD1 = 0x33, RD2 = 0xF0; swapping addresses swaps outputs; A1=0 gives RD1 = 0 regardless.
